// File: rtl/sum_stationary_pkg.sv
// Shared types and sizing helpers for the sum-stationary result collector.
package sum_stationary_pkg;

    localparam int unsigned DEF_N            = 4;
    localparam int unsigned DEF_C_DATA_WIDTH = 32;
    localparam int unsigned DEF_TILE_BITS    = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } collector_state_t;

    // Width of a counter indexing 0..n-1; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/result_accum_bank.sv
// NxN accumulator array: one beat per cycle written as a row or a column,
// either overwriting or adding; one row read combinationally.
module result_accum_bank
    import sum_stationary_pkg::*;
#(
    parameter int unsigned N            = DEF_N,
    parameter int unsigned C_DATA_WIDTH = DEF_C_DATA_WIDTH,
    parameter int unsigned ACC_WIDTH    = DEF_C_DATA_WIDTH + DEF_TILE_BITS,
    localparam int unsigned IW          = idx_width(N)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_we,
    input  logic                      i_by_row,
    input  logic [IW-1:0]             i_idx,
    input  logic                      i_overwrite,
    input  logic [N*C_DATA_WIDTH-1:0] i_data,
    input  logic [IW-1:0]             i_rd_row,
    output logic [N*ACC_WIDTH-1:0]    o_rd_data
);

    logic [ACC_WIDTH-1:0]    r_acc  [N][N];
    logic [ACC_WIDTH-1:0]    w_next [N][N];
    logic [N-1:0]            w_sel  [N];
    logic [C_DATA_WIDTH-1:0] w_elem [N][N];

    // Column beats land transposed so the array always holds row order.
    always_comb begin
        for (int unsigned r = 0; r < N; r++) begin
            w_sel[r] = '0;
            for (int unsigned c = 0; c < N; c++) begin
                w_sel[r][c]  = i_by_row ? (IW'(r) == i_idx) : (IW'(c) == i_idx);
                w_elem[r][c] = i_by_row ? i_data[c*C_DATA_WIDTH +: C_DATA_WIDTH]
                                        : i_data[r*C_DATA_WIDTH +: C_DATA_WIDTH];
                w_next[r][c] = i_overwrite ? ACC_WIDTH'(w_elem[r][c])
                                           : r_acc[r][c] + ACC_WIDTH'(w_elem[r][c]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned r = 0; r < N; r++)
                for (int unsigned c = 0; c < N; c++)
                    r_acc[r][c] <= '0;
        end else if (i_we) begin
            for (int unsigned r = 0; r < N; r++)
                for (int unsigned c = 0; c < N; c++)
                    if (w_sel[r][c])
                        r_acc[r][c] <= w_next[r][c];
        end
    end

    always_comb begin
        o_rd_data = '0;
        for (int unsigned c = 0; c < N; c++)
            o_rd_data[c*ACC_WIDTH +: ACC_WIDTH] = r_acc[i_rd_row][c];
    end

endmodule

// File: rtl/sum_stationary_result_collector.sv
// Consumes the array's C stream, sums K-split partial tiles and drains the
// finished tile row by row to a valid/ready sink.
module sum_stationary_result_collector
    import sum_stationary_pkg::*;
#(
    parameter int unsigned N            = DEF_N,
    parameter int unsigned C_DATA_WIDTH = DEF_C_DATA_WIDTH,
    parameter int unsigned TILE_BITS    = DEF_TILE_BITS,
    parameter int unsigned ACC_WIDTH    = C_DATA_WIDTH + TILE_BITS
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic                      cfg_by_row,
    input  logic [TILE_BITS-1:0]      cfg_num_tiles,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic                      in_by_row,
    input  logic [N*C_DATA_WIDTH-1:0] in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N*ACC_WIDTH-1:0]    out_data,
    output logic                      out_last,
    output logic                      busy
);

    localparam int unsigned   IW       = idx_width(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    collector_state_t     r_state, w_next_state;
    logic [IW-1:0]        r_beat, r_row;
    logic [TILE_BITS-1:0] r_tile, r_tiles;
    logic                 r_by_row;
    logic                 w_beat_fire, w_job_done, w_drain_done;
    logic [N*ACC_WIDTH-1:0] w_rd_data;

    assign w_beat_fire  = (r_state == COLLECT) && in_valid;
    assign w_job_done   = w_beat_fire && (r_beat == LAST_IDX) &&
                          (r_tile == r_tiles - TILE_BITS'(1));
    assign w_drain_done = (r_state == DRAIN) && out_ready && (r_row == LAST_IDX);

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (cfg_valid)    w_next_state = COLLECT;
            COLLECT: if (w_job_done)   w_next_state = DRAIN;
            DRAIN:   if (w_drain_done) w_next_state = IDLE;
            default:                   w_next_state = IDLE;
        endcase
    end

    always_comb begin
        cfg_ready = (r_state == IDLE);
        in_ready  = (r_state == COLLECT);
        out_valid = (r_state == DRAIN);
        out_last  = (r_state == DRAIN) && (r_row == LAST_IDX);
        busy      = (r_state != IDLE);
        in_by_row = r_by_row;
        out_data  = (r_state == DRAIN) ? w_rd_data : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_beat   <= '0;
            r_row    <= '0;
            r_tile   <= '0;
            r_tiles  <= TILE_BITS'(1);
            r_by_row <= 1'b1;
        end else begin
            case (r_state)
                IDLE: if (cfg_valid) begin
                    r_by_row <= cfg_by_row;
                    r_tiles  <= (cfg_num_tiles == '0) ? TILE_BITS'(1) : cfg_num_tiles;
                    r_beat   <= '0;
                    r_tile   <= '0;
                    r_row    <= '0;
                end
                COLLECT: if (in_valid) begin
                    if (r_beat == LAST_IDX) begin
                        r_beat <= '0;
                        r_tile <= r_tile + TILE_BITS'(1);
                    end else begin
                        r_beat <= r_beat + IW'(1);
                    end
                end
                DRAIN: if (out_ready)
                    r_row <= (r_row == LAST_IDX) ? '0 : r_row + IW'(1);
                default: ;
            endcase
        end
    end

    result_accum_bank #(
        .N           (N),
        .C_DATA_WIDTH(C_DATA_WIDTH),
        .ACC_WIDTH   (ACC_WIDTH)
    ) u_bank (
        .clk        (clk),
        .reset      (reset),
        .i_we       (w_beat_fire),
        .i_by_row   (r_by_row),
        .i_idx      (r_beat),
        .i_overwrite(r_tile == '0),
        .i_data     (in_data),
        .i_rd_row   (r_row),
        .o_rd_data  (w_rd_data)
    );

endmodule
